// File: rtl/lcd_hd44780_responder_if.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_responder_if
// Pin-level bundle of the 8-bit HD44780 character LCD bus.
//   LCD_RS        register select (0 = instruction/status, 1 = data)
//   LCD_RW        direction (0 = write, 1 = read)
//   LCD_EN        enable strobe, asynchronous to the responder clock
//   LCD_DATA      value driven by the controller
//   LCD_DATA_OUT  value returned by the panel on reads
//   LCD_DATA_OE   high while the panel drives LCD_DATA_OUT
// master = controller side, slave = panel (responder) side.
// ---------------------------------------------------------------------------
interface lcd_hd44780_responder_if;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [7:0] LCD_DATA;
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;

    modport master (
        output LCD_RS, LCD_RW, LCD_EN, LCD_DATA,
        input  LCD_DATA_OUT, LCD_DATA_OE
    );

    modport slave (
        input  LCD_RS, LCD_RW, LCD_EN, LCD_DATA,
        output LCD_DATA_OUT, LCD_DATA_OE
    );
endinterface

// File: rtl/lcd_hd44780_responder.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_responder
// Synthesizable HD44780-class character LCD: receives the 8-bit RS/RW/EN/DATA
// bus, decodes instructions and data writes into a 2x16 DDRAM, an address
// counter and mode flags, and answers busy-flag and data reads. A side port
// lets a bench or a loopback test read back the displayed characters.
//
// Ports
//   CLOCK_50    in   system clock
//   RESET       in   asynchronous active-high reset
//   lcd         slave modport of the LCD pin bus
//   BUSY        out  busy flag (also bit 7 of status reads)
//   AC          out  DDRAM address counter
//   DISP_ON     out  display-on bit
//   ERR_BUSY    out  sticky: a write arrived while busy
//   CMD_STROBE  out  one-cycle pulse per accepted write
//   RD_ADDR     in   observation index {line, col[3:0]}
//   RD_CHAR     out  DDRAM[RD_ADDR], one-cycle latency
// ---------------------------------------------------------------------------
module lcd_hd44780_responder #(
    parameter int BUSY_CYCLES = 2000,
    parameter int BUSY_CLEAR  = 76500
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET,
    lcd_hd44780_responder_if.slave        lcd,
    output logic                          BUSY,
    output logic [6:0]                    AC,
    output logic                          DISP_ON,
    output logic                          ERR_BUSY,
    output logic                          CMD_STROBE,
    input  logic [4:0]                    RD_ADDR,
    output logic [7:0]                    RD_CHAR
);

    localparam int CNT_MAX = (BUSY_CLEAR > BUSY_CYCLES) ? BUSY_CLEAR : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_CYC      = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_CLR      = CNT_W'(BUSY_CLEAR);
    // The 32-cycle fill already accounts for part of the clear busy time.
    localparam logic [CNT_W-1:0] CNT_CLR_FILL = CNT_W'(BUSY_CLEAR - 32);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // DDRAM index: line bit AC[6] on top of the 16-column offset.
    function automatic logic [4:0] ac_index(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

    // One address-counter step, wrapping between the two 16-column lines.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == 7'h0F)      nxt = 7'h40;
            else if (ac == 7'h4F) nxt = 7'h00;
            else                  nxt = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      nxt = 7'h4F;
            else if (ac == 7'h40) nxt = 7'h0F;
            else                  nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

    // Synchronizer stages and EN edge register
    logic       rs_meta_q, rs_sync_q;
    logic       rw_meta_q, rw_sync_q;
    logic       en_meta_q, en_sync_q, en_dly_q;
    logic [7:0] data_meta_q, data_sync_q;
    logic       en_rise_s, en_fall_s;

    // Architectural state
    state_t           state_q, state_d;
    logic [4:0]       fill_cnt_q, fill_cnt_d;
    logic             fill_wait_q, fill_wait_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [6:0]       ac_q, ac_d;
    logic             id_q, id_d;
    logic             disp_on_q, disp_on_d;
    logic             err_q, err_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic             oe_q, oe_d;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       rd_char_q;

    // DDRAM and its single write port
    logic [7:0] mem_q [32];
    logic       mem_we_s;
    logic [4:0] mem_widx_s;
    logic [7:0] mem_wdata_s;

    // Two-flop synchronizers on every bus pin plus the EN edge register.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            rs_meta_q   <= 1'b0;
            rs_sync_q   <= 1'b0;
            rw_meta_q   <= 1'b0;
            rw_sync_q   <= 1'b0;
            en_meta_q   <= 1'b0;
            en_sync_q   <= 1'b0;
            en_dly_q    <= 1'b0;
            data_meta_q <= 8'h00;
            data_sync_q <= 8'h00;
        end else begin
            rs_meta_q   <= lcd.LCD_RS;
            rs_sync_q   <= rs_meta_q;
            rw_meta_q   <= lcd.LCD_RW;
            rw_sync_q   <= rw_meta_q;
            en_meta_q   <= lcd.LCD_EN;
            en_sync_q   <= en_meta_q;
            en_dly_q    <= en_sync_q;
            data_meta_q <= lcd.LCD_DATA;
            data_sync_q <= data_meta_q;
        end
    end

    assign en_rise_s = en_sync_q & ~en_dly_q;
    assign en_fall_s = ~en_sync_q & en_dly_q;

    // Next-state logic: fill/wait sequencing, bus reads and write decode.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        fill_wait_d = fill_wait_q;
        wait_cnt_d  = wait_cnt_q;
        ac_d        = ac_q;
        id_d        = id_q;
        disp_on_d   = disp_on_q;
        err_d       = err_q;
        strobe_d    = 1'b0;
        oe_d        = oe_q;
        dout_d      = dout_q;
        mem_we_s    = 1'b0;
        mem_widx_s  = 5'd0;
        mem_wdata_s = 8'h00;

        case (state_q)
            ST_FILL: begin
                mem_we_s    = 1'b1;
                mem_widx_s  = fill_cnt_q;
                mem_wdata_s = 8'h20;
                if (fill_cnt_q == 5'd31) begin
                    fill_cnt_d = 5'd0;
                    if (fill_wait_q) begin
                        state_d     = ST_WAIT;
                        wait_cnt_d  = CNT_CLR_FILL;
                        fill_wait_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    fill_cnt_d = fill_cnt_q + 5'd1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_FILL;
                fill_cnt_d = 5'd0;
            end
        endcase

        // Reads are served whether or not the panel is busy.
        if (en_rise_s && rw_sync_q) begin
            oe_d = 1'b1;
            if (rs_sync_q) begin
                dout_d = mem_q[ac_index(ac_q)];
            end else begin
                dout_d = {busy_q, ac_q};
            end
        end else begin
            dout_d = dout_q;
        end

        if (en_fall_s) begin
            oe_d = 1'b0;
            if (rw_sync_q) begin
                if (rs_sync_q && !busy_q) begin
                    ac_d = ac_step(ac_q, id_q);
                end else begin
                    ac_d = ac_q;
                end
            end else if (busy_q) begin
                err_d = 1'b1;
            end else begin
                // busy_q low implies ST_IDLE, so the fill port is free here.
                strobe_d   = 1'b1;
                state_d    = ST_WAIT;
                wait_cnt_d = CNT_CYC;
                if (rs_sync_q) begin
                    mem_we_s    = 1'b1;
                    mem_widx_s  = ac_index(ac_q);
                    mem_wdata_s = data_sync_q;
                    ac_d        = ac_step(ac_q, id_q);
                end else begin
                    casez (data_sync_q)
                        8'b1???????: ac_d = {data_sync_q[6], 2'b00, data_sync_q[3:0]};
                        8'b01??????: ac_d = ac_q;
                        8'b001?????: ac_d = ac_q;
                        8'b0001????: begin
                            if (!data_sync_q[3]) begin
                                ac_d = ac_step(ac_q, data_sync_q[2]);
                            end else begin
                                ac_d = ac_q;
                            end
                        end
                        8'b00001???: disp_on_d = data_sync_q[2];
                        8'b000001??: id_d = data_sync_q[1];
                        8'b0000001?: begin
                            ac_d       = 7'h00;
                            wait_cnt_d = CNT_CLR;
                        end
                        8'b00000001: begin
                            ac_d        = 7'h00;
                            id_d        = 1'b1;
                            state_d     = ST_FILL;
                            fill_cnt_d  = 5'd0;
                            fill_wait_d = 1'b1;
                        end
                        default: ac_d = ac_q;
                    endcase
                end
            end
        end else begin
            err_d = err_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Architectural state registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_FILL;
            fill_cnt_q  <= 5'd0;
            fill_wait_q <= 1'b0;
            wait_cnt_q  <= {CNT_W{1'b0}};
            ac_q        <= 7'h00;
            id_q        <= 1'b1;
            disp_on_q   <= 1'b0;
            err_q       <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b1;
            oe_q        <= 1'b0;
            dout_q      <= 8'h00;
            rd_char_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_wait_q <= fill_wait_d;
            wait_cnt_q  <= wait_cnt_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            disp_on_q   <= disp_on_d;
            err_q       <= err_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            rd_char_q   <= mem_q[RD_ADDR];
        end
    end

    // DDRAM storage; contents are rebuilt by the fill after every reset.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we_s) begin
            mem_q[mem_widx_s] <= mem_wdata_s;
        end
    end

    assign BUSY             = busy_q;
    assign AC               = ac_q;
    assign DISP_ON          = disp_on_q;
    assign ERR_BUSY         = err_q;
    assign CMD_STROBE       = strobe_q;
    assign RD_CHAR          = rd_char_q;
    assign lcd.LCD_DATA_OUT = dout_q;
    assign lcd.LCD_DATA_OE  = oe_q;

endmodule
